shift_iter: RTL

SHIFT_ITER -- requirements
Module: shift_iter

---
 rtl/shift_iter_pkg.sv | 13 +
 rtl/shift_iter_step.sv | 32 +++
 rtl/shift_iter.sv | 101 ++++++++++
 3 files changed

// File: rtl/shift_iter_pkg.sv
// Shared encodings for the iterative shifter: operation select and controller states.
package shift_iter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_iter_step.sv
// Combinational single-step shifter: applies one shift of 0..STEP positions for any op.
module shift_step
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  input  logic [AW-1:0]    amt_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int SW = $clog2(WIDTH) + 1;

  // Left-shift distance for the rotate's wrapped half; amt_i=0 gives WIDTH, i.e. nothing wraps.
  logic [SW-1:0] wrap_amt;
  assign wrap_amt = SW'(WIDTH) - SW'(amt_i);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SLL:  data_o = data_i << amt_i;
      OP_SRL:  data_o = data_i >> amt_i;
      OP_SRA:  data_o = $unsigned($signed(data_i) >>> amt_i);
      OP_ROR:  data_o = (data_i >> amt_i) | (data_i << wrap_amt);
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle barrel shifter: shifts at most STEP positions per clock until shamt is consumed.
// Handshake: ctrl_shift is a request taken only while busy is low (IDLE); data_resultRDY pulses
// for exactly one cycle with data_result valid, and data_result holds until the next result.
module shift_iter
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ctrl_shift,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic [WIDTH-1:0]         data_result,
  output logic                     data_resultRDY,
  output logic                     busy,
  output logic [1:0]               dbg_state_o
);

  localparam int RW = $clog2(WIDTH);
  localparam int AW = $clog2(STEP) + 1;
  localparam logic [RW-1:0] STEP_R = RW'(STEP);

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AW-1:0]    step_amt;
  logic [WIDTH-1:0] step_out;

  assign step_amt = (rem_q > STEP_R) ? AW'(STEP) : AW'(rem_q);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i (work_q),
    .op_i   (op_q),
    .amt_i  (step_amt),
    .data_o (step_out)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    work_d   = work_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_shift) begin
          op_d   = op;
          work_d = data_in;
          rem_d  = shamt;
          if (shamt == '0) begin
            result_d = data_in;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = step_out;
        rem_d  = rem_q - RW'(step_amt);
        // Last step: publish the final value as the controller enters DONE.
        if (rem_q == RW'(step_amt)) begin
          result_d = step_out;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      rem_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      work_q   <= work_d;
      result_q <= result_d;
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state_o    = state_q;

endmodule
